// File: rtl/fp32_divider_if.sv
// Handshake and data bundle for the FP32 divider: request side (start, A, B)
// and response side (busy, done, result, exception flags).
interface fp32_divider_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        invalid;
  logic        div_by_zero;
  logic        overflow;
  logic        underflow;

  modport master (
    output start, A, B,
    input  busy, done, result, invalid, div_by_zero, overflow, underflow
  );

  modport slave (
    input  start, A, B,
    output busy, done, result, invalid, div_by_zero, overflow, underflow
  );
endinterface

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 single-precision divider. A restoring mantissa divider
// produces one quotient bit per clock (25 bits), followed by a single
// normalize/range-check step. Denormals flush to zero, rounding truncates.
// Special operands bypass the divide loop and finish two clocks after start.
module fp32_divider (
  input  logic               clk,
  input  logic               rst,
  fp32_divider_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPECIAL,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;

  // Operand fields of the request currently presented on the bus
  logic        sa, sb, sgn;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  // Special-case resolution of the presented operands
  logic        spec_hit;
  logic [31:0] spec_val;
  logic        spec_inv;
  logic        spec_dbz;

  // Working registers of the divide loop (no reset: always loaded on accept)
  logic                sp_hit;
  logic [31:0]         sp_res;
  logic                sp_inv;
  logic                sp_dbz;
  logic [24:0]         rem;
  logic [23:0]         mb;
  logic [24:0]         quo;
  logic signed [9:0]   exp_e;
  logic                sign_r;

  // One restoring step
  logic                q_bit;
  logic [24:0]         diff;
  logic [24:0]         rem_next;

  logic [33:0]         packed_res;

  // Truncating normalization plus overflow/underflow saturation.
  // Returns {overflow, underflow, result}.
  function automatic logic [33:0] normalize_pack(input logic s,
                                                 input logic signed [9:0] e,
                                                 input logic [24:0] q);
    logic signed [9:0] ex;
    logic [22:0]       fr;
    if (q[24]) begin
      fr = q[23:1];
      ex = e;
    end else begin
      fr = q[22:0];
      ex = e - 10'sd1;
    end
    if (ex >= 10'sd255)
      return {1'b1, 1'b0, s, 8'hFF, 23'h0};
    else if (ex <= 10'sd0)
      return {1'b0, 1'b1, s, 31'h0};
    else
      return {1'b0, 1'b0, s, ex[7:0], fr};
  endfunction

  assign sa = bus.A[31];
  assign ea = bus.A[30:23];
  assign fa = bus.A[22:0];
  assign sb = bus.B[31];
  assign eb = bus.B[30:23];
  assign fb = bus.B[22:0];
  assign sgn    = sa ^ sb;
  assign a_nan  = (ea == 8'hFF) && (fa != 23'h0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'h0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'h0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'h0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  // Resolve special operands in priority order
  always_comb begin
    spec_hit = 1'b1;
    spec_val = 32'h0;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (a_nan) begin
      spec_val = bus.A;
    end else if (b_nan) begin
      spec_val = bus.B;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val = 32'h7FC0_0000;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_val = {sgn, 8'hFF, 23'h0};
    end else if (b_zero) begin
      spec_val = {sgn, 8'hFF, 23'h0};
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_val = {sgn, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  assign q_bit    = (rem >= {1'b0, mb});
  assign diff     = q_bit ? (rem - {1'b0, mb}) : rem;
  assign rem_next = diff << 1;

  assign packed_res = normalize_pack(sign_r, exp_e, quo);

  // Operand latch on accept, then one restoring divide step per DIVIDE cycle
  always_ff @(posedge clk) begin
    if ((state == S_IDLE || state == S_DONE) && bus.start) begin
      sp_hit <= spec_hit;
      sp_res <= spec_val;
      sp_inv <= spec_inv;
      sp_dbz <= spec_dbz;
      rem    <= {2'b01, fa};
      mb     <= {1'b1, fb};
      quo    <= 25'h0;
      exp_e  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
      sign_r <= sgn;
    end else if (state == S_DIVIDE) begin
      rem <= rem_next;
      quo <= {quo[23:0], q_bit};
    end
  end

  // Control FSM with registered handshake, result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= 5'd0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.result      <= 32'h0;
      bus.invalid     <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.underflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy        <= 1'b1;
            bus.invalid     <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.underflow   <= 1'b0;
            cnt             <= 5'd0;
            state           <= spec_hit ? S_SPECIAL : S_DIVIDE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SPECIAL: begin
          state <= S_NORM;
        end
        S_DIVIDE: begin
          if (cnt == 5'd24) begin
            cnt   <= 5'd0;
            state <= S_NORM;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_NORM: begin
          if (sp_hit) begin
            bus.result      <= sp_res;
            bus.invalid     <= sp_inv;
            bus.div_by_zero <= sp_dbz;
          end else begin
            bus.result    <= packed_res[31:0];
            bus.overflow  <= packed_res[33];
            bus.underflow <= packed_res[32];
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
